lane_mode_scheduler: RTL and testbench
======================================

// Module: lane_mode_scheduler
// PURPOSE
//  Runtime controller and pipelined datapath for per-lane invert/pass/rotate transforms.
//  It splits each data word into LANES lanes of LANE_W bits.
//  Each lane is transformed using its own 2-bit mode register.
//  Mode registers are double-buffered (shadow/active) and committed atomically at word boundaries.
//  This replaces elaboration-time mode selection with run-time configuration.
// PARAMETERS
//  LANES        2  number of lanes per word (>=1)
//  LANE_W       4  bits per lane (>=2)
//  DEFAULT_MODE 0  mode loaded into every shadow and active register at reset (0..2)
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              synchronous, active-high reset
//  cfg_we     in   1              write cfg_mode into shadow[cfg_lane]
//  cfg_lane   in   LIDX_W         lane index; LIDX_W = max(1,$clog2(LANES))
//  cfg_mode   in   2              0 invert, 1 pass, 2 rotate-left-by-1, 3 reserved
//  cfg_commit in   1              copy all shadow regs to active regs
//  cfg_err    out  1              1-cycle pulse on an illegal config write
//  in_valid   in   1              input word valid
//  in_ready   out  1              block accepts the word this cycle
//  in_data    in   LANES*LANE_W   lane k = in_data[k*LANE_W +: LANE_W]
//  out_valid  out  1              output word valid
//  out_ready  in   1              downstream accepts the output word
//  out_data   out  LANES*LANE_W   transformed word
//  word_cnt   out  16             count of completed output handshakes
// BEHAVIOUR
//  Reset values: out_valid=0, out_data=0, word_cnt=0, cfg_err=0.
//   All shadow and active mode regs = DEFAULT_MODE. The held word is discarded.
//  FSM states:
//   EMPTY (out_valid=0) -> FULL on in_valid.
//   FULL: stays FULL if out_ready && in_valid; -> EMPTY if out_ready && !in_valid.
//   FULL holds (no change) if !out_ready.
//  in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
//  Latency: out_data is valid 1 cycle after accept. Full throughput: 1 word/cycle.
//  The transform uses the active mode at the accept cycle. The result is registered.
//   mode 0: ~lane
//   mode 1: lane
//   mode 2: {lane[LANE_W-2:0], lane[LANE_W-1]}
//  While FULL && !out_ready: out_data and out_valid are held stable.
//   Later config changes do not affect a held word.
//  cfg_we:
//   cfg_lane >= LANES -> write ignored, cfg_err pulses.
//   cfg_mode == 3 -> shadow stores 1 (pass), cfg_err pulses.
//  cfg_commit: active <= shadow at that clock edge.
//   A word accepted in the same cycle as the commit uses the OLD active modes.
//  cfg_we and cfg_commit in the same cycle: commit copies the pre-write shadow.
//   The new write lands in shadow only and needs a later commit.
//  word_cnt increments on out_valid && out_ready. It wraps 16'hFFFF -> 0.
//  Reset asserted mid-operation overrides every other input in that cycle.
// CONFIGURATION
//  Macro LANE_MODE_READBACK_EN.
//   Defined: adds output port cfg_rdata [2*LANES-1:0].
//    It is registered and is the concatenation of the active modes (lane k at [2k+:2]).
//    It updates on the cycle after a commit and resets to DEFAULT_MODE replicated.
//   Undefined: the port and its register do not exist. All other behaviour is identical.
// TESTING (LANES=2, LANE_W=4, DEFAULT_MODE=0)
//  1. After reset, send 8'hCA -> out_data=8'h35 exactly 1 cycle later; word_cnt=1.
//  2. Write lane0 mode1 with no commit, send 8'hCA -> 8'h35.
//     Then commit and send 8'hCA -> 8'h3A.
//  3. Write lane0=2 and lane1=0, commit, send 8'hAF -> 8'h5F.
//     Assert commit in the same cycle as accepting 8'hCA -> the old modes are applied.
//  4. Send 8'hCA with out_ready=0 for 3 cycles -> in_ready=0, out_data=8'h35 stable.
//     word_cnt does not change until the handshake.
//  5. Write cfg_mode=3 and write cfg_lane=2 -> cfg_err pulses for 1 cycle each;
//     after commit, lane0 passes its data through.
//  6. Preload word_cnt to 16'hFFFF via 65535 words -> the next handshake gives 0.
//     Assert rst while FULL -> out_valid=0 on the next cycle.

Source files
------------

// File: rtl/lane_mode_scheduler.sv
// Per-lane invert/pass/rotate datapath with double-buffered run-time lane modes, one-word output register.
// Optional feature macro LANE_MODE_READBACK_EN adds a registered cfg_rdata view of the active modes.
module lane_mode_scheduler #(
  parameter  int LANES        = 2,
  parameter  int LANE_W       = 4,
  parameter  int DEFAULT_MODE = 0,
  localparam int LIDX_W       = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int DW           = LANES * LANE_W,
  localparam int MW           = 2 * LANES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [LIDX_W-1:0] cfg_lane,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_commit,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [15:0]       word_cnt
`ifdef LANE_MODE_READBACK_EN
  ,
  output logic [MW-1:0]     cfg_rdata
`endif
);

  localparam logic [MW-1:0] MODES_RST = {LANES{2'(DEFAULT_MODE)}};

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [MW-1:0]   shadow_q, shadow_d;
  logic [MW-1:0]   active_q, active_d;
  logic            accept, handshake, lane_ok;
  logic [1:0]      mode_fix;

  function automatic logic [DW-1:0] xform(input logic [DW-1:0] d, input logic [MW-1:0] m);
    logic [LANE_W-1:0] l;
    xform = '0;
    for (int k = 0; k < LANES; k++) begin
      l = d[k*LANE_W +: LANE_W];
      case (m[2*k +: 2])
        2'd0:    xform[k*LANE_W +: LANE_W] = ~l;
        2'd2:    xform[k*LANE_W +: LANE_W] = {l[LANE_W-2:0], l[LANE_W-1]};
        default: xform[k*LANE_W +: LANE_W] = l;
      endcase
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (in_valid) state_d = FULL;
      FULL:    if (out_ready && !in_valid) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == FULL);
    in_ready  = !out_valid || out_ready;
  end

  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign lane_ok   = (int'(cfg_lane) < LANES);
  assign mode_fix  = (cfg_mode == 2'd3) ? 2'd1 : cfg_mode;

  // Transform reads active_q, so a commit on the accept edge still applies the old modes.
  always_comb begin
    data_d   = accept ? xform(in_data, active_q) : data_q;
    cnt_d    = cnt_q + {15'd0, handshake};
    err_d    = cfg_we && (!lane_ok || cfg_mode == 2'd3);
    active_d = cfg_commit ? shadow_q : active_q;
    shadow_d = shadow_q;
    for (int k = 0; k < LANES; k++) begin
      if (cfg_we && lane_ok && cfg_lane == LIDX_W'(k)) shadow_d[2*k +: 2] = mode_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      shadow_q <= MODES_RST;
      active_q <= MODES_RST;
    end else begin
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign out_data = data_q;
  assign word_cnt = cnt_q;
  assign cfg_err  = err_q;

`ifdef LANE_MODE_READBACK_EN
  logic [MW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= MODES_RST;
    else     rdata_q <= active_q;
  end

  assign cfg_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_lane_mode_scheduler.sv
// Directed and randomized bench for lane_mode_scheduler against a transaction-level model.
module tb_lane_mode_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cfg_we, cfg_lane, cfg_commit, in_valid, out_ready;
  logic [1:0]  cfg_mode;
  logic [7:0]  in_data, out_data;
  logic        cfg_err, in_ready, out_valid;
  logic [15:0] word_cnt;

  logic        rst3, we3, commit3, iv3, ir3, ov3, ordy3, err3;
  logic [1:0]  lane3, mode3;
  logic [11:0] id3, od3;
  logic [15:0] cnt3;
`ifdef LANE_MODE_READBACK_EN
  logic [3:0]  cfg_rdata;
  logic [5:0]  cfg_rdata3;
`endif

  lane_mode_scheduler #(.LANES(2), .LANE_W(4), .DEFAULT_MODE(0)) u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_lane(cfg_lane), .cfg_mode(cfg_mode),
    .cfg_commit(cfg_commit), .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .word_cnt(word_cnt)
`ifdef LANE_MODE_READBACK_EN
    , .cfg_rdata(cfg_rdata)
`endif
  );

  lane_mode_scheduler #(.LANES(3), .LANE_W(4), .DEFAULT_MODE(0)) u_dut3 (
    .clk(clk), .rst(rst3), .cfg_we(we3), .cfg_lane(lane3), .cfg_mode(mode3),
    .cfg_commit(commit3), .cfg_err(err3), .in_valid(iv3), .in_ready(ir3),
    .in_data(id3), .out_valid(ov3), .out_ready(ordy3), .out_data(od3),
    .word_cnt(cnt3)
`ifdef LANE_MODE_READBACK_EN
    , .cfg_rdata(cfg_rdata3)
`endif
  );

  int    checks = 0;
  int    errors = 0;
  string step   = "init";

  // Reference model: lane modes as plain integers, one held output word.
  int          m_shadow[2];
  int          m_active[2];
  logic        m_valid = 1'b0;
  logic        m_err   = 1'b0;
  logic [7:0]  m_data  = 8'h00;
  logic [15:0] m_cnt   = 16'h0000;
  logic [3:0]  m_rdata = 4'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
    end
  endtask

  function automatic int ref_lane(input int v, input int mode);
    if (mode == 0) return 15 - v;
    if (mode == 2) return (v * 2) % 16 + v / 8;
    return v;
  endfunction

  function automatic logic [7:0] ref_word(input logic [7:0] d);
    int lo, hi;
    lo = ref_lane(int'(d[3:0]), m_active[0]);
    hi = ref_lane(int'(d[7:4]), m_active[1]);
    return 8'(hi * 16 + lo);
  endfunction

  task automatic model_step();
    logic acc, hs;
    if (rst) begin
      m_valid = 1'b0; m_data = 8'h00; m_cnt = 16'h0000; m_err = 1'b0; m_rdata = 4'h0;
      for (int k = 0; k < 2; k++) begin m_shadow[k] = 0; m_active[k] = 0; end
    end else begin
      acc = in_valid && (!m_valid || out_ready);
      hs  = m_valid && out_ready;
      m_rdata = 4'(m_active[1] * 4 + m_active[0]);
      if (acc) m_data = ref_word(in_data);
      m_valid = acc ? 1'b1 : (hs ? 1'b0 : m_valid);
      if (hs) m_cnt = m_cnt + 16'd1;
      m_err = cfg_we && (int'(cfg_lane) >= 2 || cfg_mode == 2'd3);
      if (cfg_commit) m_active = m_shadow;
      if (cfg_we && int'(cfg_lane) < 2) m_shadow[int'(cfg_lane)] = (cfg_mode == 2'd3) ? 1 : int'(cfg_mode);
    end
  endtask

  // Inputs are set by the caller shortly after a rising edge; outputs checked 1 after the next one.
  task automatic cycle();
    #2;
    chk("in_ready", in_ready, !m_valid || out_ready);
    model_step();
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("word_cnt", word_cnt, m_cnt);
    chk("cfg_err", cfg_err, m_err);
`ifdef LANE_MODE_READBACK_EN
    chk("cfg_rdata", cfg_rdata, m_rdata);
`endif
  endtask

  task automatic idle_inputs();
    rst = 1'b0; cfg_we = 1'b0; cfg_lane = 1'b0; cfg_mode = 2'd0; cfg_commit = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
  endtask

  task automatic cfg_write(input logic lane, input logic [1:0] mode);
    cfg_we = 1'b1; cfg_lane = lane; cfg_mode = mode;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1; in_data = d;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin m_shadow[k] = 0; m_active[k] = 0; end
    idle_inputs();
    rst3 = 1'b1; we3 = 1'b0; lane3 = 2'd0; mode3 = 2'd0; commit3 = 1'b0;
    iv3 = 1'b0; id3 = 12'h000; ordy3 = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    step = "reset";
    cycle();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_cnt", word_cnt, 16'h0000);
    chk("rst_err", cfg_err, 1'b0);
    rst = 1'b0;

    step = "t1";
    send(8'hCA);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, 8'h35);
    cycle();
    chk("t1_cnt", word_cnt, 16'd1);

    step = "t2";
    cfg_write(1'b0, 2'd1);
    send(8'hCA);
    chk("t2_nocommit", out_data, 8'h35);
    cfg_commit = 1'b1; cycle(); cfg_commit = 1'b0;
    send(8'hCA);
    chk("t2_commit", out_data, 8'h3A);
    cycle();

    step = "t3";
    cfg_write(1'b0, 2'd2);
    cfg_write(1'b1, 2'd0);
    cfg_commit = 1'b1; cycle(); cfg_commit = 1'b0;
    send(8'hAF);
    chk("t3_rot", out_data, 8'h5F);
    cfg_write(1'b0, 2'd1);
    cfg_commit = 1'b1; send(8'hCA); cfg_commit = 1'b0;
    chk("t3_same_cycle_commit", out_data, 8'h35);
    send(8'hCA);
    chk("t3_after_commit", out_data, 8'h3A);
    cycle();

    step = "t4";
    rst = 1'b1; cycle(); rst = 1'b0;
    out_ready = 1'b0;
    send(8'hCA);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h11;
      cfg_we = 1'b1; cfg_lane = 1'b0; cfg_mode = 2'd1; cfg_commit = (i == 1);
      #1;
      chk("t4_in_ready", in_ready, 1'b0);
      cycle();
      chk("t4_hold_data", out_data, 8'h35);
      chk("t4_hold_cnt", word_cnt, 16'd0);
    end
    idle_inputs();
    cycle();
    chk("t4_cnt", word_cnt, 16'd1);
    chk("t4_empty", out_valid, 1'b0);

    step = "t5";
    cfg_write(1'b0, 2'd3);
    chk("t5_err_pulse", cfg_err, 1'b1);
    cycle();
    chk("t5_err_clear", cfg_err, 1'b0);
    cfg_commit = 1'b1; cycle(); cfg_commit = 1'b0;
    send(8'hCA);
    chk("t5_lane0_pass", out_data[3:0], 4'hA);
    cfg_commit = 1'b1; cfg_write(1'b1, 2'd1); cfg_commit = 1'b0;
    send(8'hCA);
    chk("t5_we_commit_same", out_data, 8'h3A);
    cfg_commit = 1'b1; cycle(); cfg_commit = 1'b0;
    send(8'hCA);
    chk("t5_late_commit", out_data, 8'hCA);
    cycle();

    step = "t5_lanes3";
    @(posedge clk); #1;
    rst3 = 1'b0;
    chk("l3_ready", ir3, 1'b1);
    we3 = 1'b1; lane3 = 2'd3; mode3 = 2'd1;
    @(posedge clk); #1;
    chk("l3_bad_lane_err", err3, 1'b1);
    lane3 = 2'd2;
    @(posedge clk); #1;
    chk("l3_good_lane_err", err3, 1'b0);
    we3 = 1'b0; commit3 = 1'b1;
    @(posedge clk); #1;
    commit3 = 1'b0; iv3 = 1'b1; id3 = 12'hCA5;
    @(posedge clk); #1;
    iv3 = 1'b0;
    chk("l3_data", od3, 12'hC5A);
    @(posedge clk); #1;
    chk("l3_cnt", cnt3, 16'd1);

    step = "random";
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 63) == 0);
      in_valid   = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 3) != 0);
      cfg_we     = ($urandom_range(0, 3) == 0);
      cfg_lane   = 1'($urandom_range(0, 1));
      cfg_mode   = 2'($urandom_range(0, 3));
      cfg_commit = ($urandom_range(0, 7) == 0);
      in_data    = 8'($urandom);
      cycle();
    end
    idle_inputs();

    step = "t6";
    rst = 1'b1; cycle(); rst = 1'b0;
    in_valid = 1'b1; in_data = 8'hCA;
    for (int i = 0; i < 65536; i++) cycle();
    chk("t6_cnt_max", word_cnt, 16'hFFFF);
    in_valid = 1'b0;
    cycle();
    chk("t6_cnt_wrap", word_cnt, 16'h0000);
    out_ready = 1'b0;
    send(8'h5A);
    chk("t6_full", out_valid, 1'b1);
    rst = 1'b1; in_valid = 1'b1;
    cycle();
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_data", out_data, 8'h00);
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
